uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice: byte width,
// arbiter state encoding and a ceiling-log2 helper for sizing counters.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Never returns less than 1 so a width derived from it is always legal.
  function automatic int Clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: picks the first active request after last_id,
// wrapping from NUM_REQ-1 back to 0.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last_id,
  output logic [2:0]         winner,
  output logic               any_req
);

  int   idx;
  logic found;

  always_comb begin
    winner = last_id;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_id) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          winner = 3'(j);
          found  = 1'b1;
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources,
// sequencing the Start / ready handshake and flagging a transmitter that never responds.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                      Clk_TX,
  input  logic                      Reset_T,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [BYTE_W*NUM_REQ-1:0] Data_In,
  output logic [NUM_REQ-1:0]        Ack,
  input  logic                      Tx_Ready,
  output logic                      Tx_Start,
  output logic [BYTE_W-1:0]         Tx_Data,
  output logic                      Busy,
  output logic [2:0]                Cur_Id,
  output logic                      Err
);

  localparam int TIMER_W = Clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [2:0]           winner;
  logic                 any_req;
  logic [BYTE_W-1:0]    win_byte;
  logic [NUM_REQ-1:0]   win_onehot;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (Req),
    .last_id (Cur_Id),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_byte   = '0;
    win_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == 3'(j)) begin
        win_byte      = Data_In[j*BYTE_W +: BYTE_W];
        win_onehot[j] = 1'b1;
      end
    end
  end

  // Start stays low from START onward, so the transmitter's edge detector
  // always sees at least two low cycles between consecutive pulses.
  always_ff @(posedge Clk_TX or negedge Reset_T) begin
    if (!Reset_T) begin
      state    <= IDLE;
      timer    <= '0;
      Ack      <= '0;
      Tx_Start <= 1'b0;
      Tx_Data  <= '1;
      Busy     <= 1'b0;
      Cur_Id   <= 3'(NUM_REQ - 1);
      Err      <= 1'b0;
    end else begin
      Err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && Tx_Ready) begin
            Tx_Data  <= win_byte;
            Cur_Id   <= winner;
            Ack      <= win_onehot;
            Tx_Start <= 1'b1;
            Busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          Tx_Start <= 1'b0;
          Ack      <= '0;
          timer    <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!Tx_Ready) begin
            state <= WAIT_DONE;
          end else if (timer == TIMER_W'(BUSY_TIMEOUT - 1)) begin
            // Transmitter ignored the strobe: drop the byte rather than retry.
            Err   <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (Tx_Ready) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model of grants,
// a simple transmitter model driving Tx_Ready, and randomized requesters.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 4;

  logic                   Clk_TX;
  logic                   Reset_T;
  logic [NUM_REQ-1:0]     Req;
  logic [8*NUM_REQ-1:0]   Data_In;
  logic [NUM_REQ-1:0]     Ack;
  logic                   Tx_Ready;
  logic                   Tx_Start;
  logic [7:0]             Tx_Data;
  logic                   Busy;
  logic [2:0]             Cur_Id;
  logic                   Err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  bit         m_idle;
  int         m_last;
  logic [7:0] m_txdata;
  int         m_free_at;
  bit         m_timeout;
  int         uart_fall_at;
  int         uart_rise_at;
  bit         dead_uart = 0;
  int         req_mode  = 0;
  logic [7:0] req_data [NUM_REQ];
  int         low_run;
  int         obs_starts = 0;
  int         obs_errs   = 0;
  int         obs_order [$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .Clk_TX   (Clk_TX),
    .Reset_T  (Reset_T),
    .Req      (Req),
    .Data_In  (Data_In),
    .Ack      (Ack),
    .Tx_Ready (Tx_Ready),
    .Tx_Start (Tx_Start),
    .Tx_Data  (Tx_Data),
    .Busy     (Busy),
    .Cur_Id   (Cur_Id),
    .Err      (Err)
  );

  initial Clk_TX = 1'b0;
  always #5 Clk_TX = ~Clk_TX;

  function automatic int rr_ref(input int last, input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) Data_In[8*i +: 8] = req_data[i];
  endtask

  task automatic model_reset();
    m_idle       = 1'b1;
    m_last       = NUM_REQ - 1;
    m_txdata     = 8'hFF;
    m_free_at    = -1;
    m_timeout    = 1'b0;
    uart_fall_at = -1;
    uart_rise_at = -1;
    low_run      = 2;
  endtask

  // One clock: predict this cycle's outputs from the transaction model, compare,
  // then let the transmitter model and the requesters react.
  task automatic step();
    logic [NUM_REQ-1:0]   seen_req;
    logic [8*NUM_REQ-1:0] seen_data;
    logic                 seen_ready;
    logic                 exp_start;
    logic                 exp_err;
    logic [NUM_REQ-1:0]   exp_ack;
    int                   w;
    int                   d;
    int                   l;
    seen_req   = Req;
    seen_data  = Data_In;
    seen_ready = Tx_Ready;
    @(posedge Clk_TX);
    #1;
    cyc++;
    exp_start = 1'b0;
    exp_err   = 1'b0;
    exp_ack   = '0;
    if (m_idle && seen_ready && seen_req != '0) begin
      w         = rr_ref(m_last, seen_req);
      exp_start = 1'b1;
      exp_ack   = NUM_REQ'(1) << w;
      m_last    = w;
      m_txdata  = seen_data[8*w +: 8];
      m_idle    = 1'b0;
      if (dead_uart) begin
        m_free_at = cyc + BUSY_TIMEOUT + 1;
        m_timeout = 1'b1;
      end else begin
        d            = int'($urandom_range(0, 2));
        l            = int'($urandom_range(3, 8));
        uart_fall_at = cyc + d;
        uart_rise_at = cyc + d + l;
        m_free_at    = uart_rise_at + 1;
        m_timeout    = 1'b0;
      end
    end else if (!m_idle && cyc == m_free_at) begin
      m_idle  = 1'b1;
      exp_err = m_timeout;
    end

    vectors++;
    if (Tx_Start !== exp_start) begin
      miscompares++;
      $display("[TB] FAIL tx_start cyc=%0d got=%b expected=%b", cyc, Tx_Start, exp_start);
    end
    vectors++;
    if (Ack !== exp_ack) begin
      miscompares++;
      $display("[TB] FAIL ack cyc=%0d got=%b expected=%b", cyc, Ack, exp_ack);
    end
    vectors++;
    if (Busy !== !m_idle) begin
      miscompares++;
      $display("[TB] FAIL busy cyc=%0d got=%b expected=%b", cyc, Busy, !m_idle);
    end
    vectors++;
    if (Err !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL err cyc=%0d got=%b expected=%b", cyc, Err, exp_err);
    end
    vectors++;
    if (Cur_Id !== 3'(m_last)) begin
      miscompares++;
      $display("[TB] FAIL cur_id cyc=%0d got=%0d expected=%0d", cyc, Cur_Id, m_last);
    end
    vectors++;
    if (Tx_Data !== m_txdata) begin
      miscompares++;
      $display("[TB] FAIL tx_data cyc=%0d got=%h expected=%h", cyc, Tx_Data, m_txdata);
    end

    if (Tx_Start === 1'b1) begin
      obs_starts++;
      obs_order.push_back(int'(Cur_Id));
      vectors++;
      if (low_run < 2) begin
        miscompares++;
        $display("[TB] FAIL start_gap cyc=%0d got=%0d low cycles expected>=2", cyc, low_run);
      end
      vectors++;
      if (seen_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL start_while_busy cyc=%0d tx_ready=%b expected=1", cyc, seen_ready);
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    if (Err === 1'b1) obs_errs++;

    if (cyc == uart_fall_at) Tx_Ready = 1'b0;
    if (cyc == uart_rise_at) Tx_Ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      case (req_mode)
        0: if (exp_ack[i]) Req[i] = 1'b0;
        1: begin
          if (exp_ack[i]) begin
            if ($urandom_range(0, 1) == 0) Req[i] = 1'b0;
            req_data[i] = 8'($urandom);
          end else if (!Req[i]) begin
            if ($urandom_range(0, 9) < 3) begin
              Req[i]      = 1'b1;
              req_data[i] = 8'($urandom);
            end
          end else if ($urandom_range(0, 19) == 0) begin
            Req[i] = 1'b0;
          end
        end
        default: if (exp_ack[i]) req_data[i] = 8'($urandom);
      endcase
    end
    drive_data();
  endtask

  task automatic apply_reset();
    Reset_T = 1'b0;
    Req     = '0;
    #1;
    @(posedge Clk_TX);
    #1;
    model_reset();
    Tx_Ready = 1'b1;
    Reset_T  = 1'b1;
  endtask

  task automatic drain();
    req_mode = 0;
    Req      = '0;
    for (int n = 0; n < 40 && !m_idle; n++) step();
    vectors++;
    if (!m_idle) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout got=busy expected=idle within 40 cycles");
    end
  endtask

  task automatic test_reset();
    Reset_T  = 1'b0;
    Req      = '0;
    Tx_Ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_data[i] = 8'h00;
    drive_data();
    model_reset();
    @(posedge Clk_TX);
    #1;
    vectors++;
    if (Ack !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ack got=%b expected=0000", Ack); end
    vectors++;
    if (Tx_Start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start got=%b expected=0", Tx_Start); end
    vectors++;
    if (Tx_Data !== 8'hFF) begin miscompares++; $display("[TB] FAIL reset_data got=%h expected=ff", Tx_Data); end
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b expected=0", Busy); end
    vectors++;
    if (Cur_Id !== 3'd3) begin miscompares++; $display("[TB] FAIL reset_cur_id got=%0d expected=3", Cur_Id); end
    vectors++;
    if (Err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got=%b expected=0", Err); end
    Reset_T = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_single_byte();
    int starts_before;
    apply_reset();
    req_mode    = 0;
    Tx_Ready    = 1'b0;
    req_data[0] = 8'hA5;
    Req         = 4'b0001;
    drive_data();
    starts_before = obs_starts;
    repeat (3) step();
    vectors++;
    if (obs_starts != starts_before) begin
      miscompares++;
      $display("[TB] FAIL grant_while_not_ready got=%0d starts expected=0", obs_starts - starts_before);
    end
    Tx_Ready = 1'b1;
    step();
    vectors++;
    if (Ack !== 4'b0001 || Tx_Data !== 8'hA5 || Tx_Start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_grant got ack=%b data=%h start=%b expected ack=0001 data=a5 start=1",
               Ack, Tx_Data, Tx_Start);
    end
    drain();
  endtask

  task automatic test_fairness();
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    apply_reset();
    req_mode = 2;
    for (int i = 0; i < NUM_REQ; i++) req_data[i] = 8'($urandom);
    drive_data();
    Req = 4'b1111;
    obs_order.delete();
    for (int n = 0; n < 300 && obs_order.size() < 8; n++) step();
    vectors++;
    if (obs_order.size() < 8) begin
      miscompares++;
      $display("[TB] FAIL fairness_count got=%0d grants expected=8", obs_order.size());
    end
    for (int k = 0; k < 8; k++) begin
      if (k < obs_order.size()) begin
        vectors++;
        if (obs_order[k] != exp_order[k]) begin
          miscompares++;
          $display("[TB] FAIL fairness_order idx=%0d got=%0d expected=%0d", k, obs_order[k], exp_order[k]);
        end
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int starts_before;
    req_mode = 2;
    Req      = 4'b1001 | 4'($urandom);
    drive_data();
    starts_before = obs_starts;
    for (int n = 0; n < 300 && obs_starts - starts_before < 8; n++) step();
    vectors++;
    if (obs_starts - starts_before < 8) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_count got=%0d starts expected=8", obs_starts - starts_before);
    end
    drain();
  endtask

  task automatic test_timeout();
    int errs_before;
    apply_reset();
    dead_uart   = 1'b1;
    req_mode    = 0;
    req_data[1] = 8'($urandom);
    drive_data();
    Req         = 4'b0010;
    errs_before = obs_errs;
    repeat (12) step();
    vectors++;
    if (obs_errs - errs_before != 1) begin
      miscompares++;
      $display("[TB] FAIL timeout_err_count got=%0d expected=1", obs_errs - errs_before);
    end
    vectors++;
    if (Cur_Id !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL timeout_cur_id got=%0d expected=1", Cur_Id);
    end
    dead_uart = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_frame();
    bit reached;
    apply_reset();
    req_mode    = 0;
    req_data[2] = 8'($urandom);
    drive_data();
    Req     = 4'b0100;
    reached = 1'b0;
    for (int n = 0; n < 40 && !reached; n++) begin
      step();
      if (!m_idle && cyc == uart_fall_at + 2) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("[TB] FAIL mid_frame_reach got=not reached expected=wait_done within 40 cycles");
    end
    #2;
    Reset_T = 1'b0;
    #1;
    vectors++;
    if (Ack !== 4'b0000 || Tx_Start !== 1'b0 || Err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_pulses got ack=%b start=%b err=%b expected 0000/0/0", Ack, Tx_Start, Err);
    end
    vectors++;
    if (Busy !== 1'b0 || Cur_Id !== 3'd3 || Tx_Data !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL async_reset_state got busy=%b cur_id=%0d data=%h expected 0/3/ff", Busy, Cur_Id, Tx_Data);
    end
    @(posedge Clk_TX);
    #1;
    model_reset();
    Tx_Ready    = 1'b1;
    req_data[0] = 8'h3C;
    drive_data();
    Req     = 4'b0001;
    Reset_T = 1'b1;
    step();
    vectors++;
    if (Ack !== 4'b0001 || Tx_Start !== 1'b1 || Tx_Data !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL post_reset_grant got ack=%b start=%b data=%h expected 0001/1/3c", Ack, Tx_Start, Tx_Data);
    end
    drain();
  endtask

  task automatic test_random();
    apply_reset();
    req_mode = 1;
    Req      = '0;
    repeat (500) step();
    drain();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fairness();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=simulation still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
